// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one registered-read RAM port between a scan-out prefetch FIFO and a CPU.
// Scan reads refill the pixel FIFO. A refill wins outright when the FIFO is close to empty.
// Otherwise the CPU wins, and it can take at most one access every two cycles.
module vram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_WORDS = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_en,
    input  logic              frame_start,
    input  logic              pix_en,
    output logic [DATA_W-1:0] pixel,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    localparam int CW    = $clog2(FIFO_DEPTH);
    localparam int OCC_W = CW + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic              inflight_q, inflight_d;
    logic [CW:0]       count_q, count_d;
    logic [CW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic              underflow_q, underflow_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic [OCC_W-1:0]  occ;
    logic              scan_elig, cpu_elig, urgent, scan_gnt, cpu_gnt, push, pop;

    // Arbitration: an urgent refill beats the CPU, the CPU beats a routine refill.
    // frame_start blocks scan grants and throws away the returning scan word.
    always_comb begin
        occ       = OCC_W'(count_q) + OCC_W'(inflight_q);
        scan_elig = scan_en && (occ < OCC_W'(FIFO_DEPTH)) && !frame_start;
        cpu_elig  = cpu_req && (state_q == S_IDLE);
        urgent    = scan_elig && (occ < OCC_W'(2));
        scan_gnt  = !reset && (urgent || (scan_elig && !cpu_elig));
        cpu_gnt   = !reset && !urgent && cpu_elig;
        push      = inflight_q && !frame_start;
        pop       = pix_en && (count_q != '0) && !frame_start;
    end

    // Next-state for the scan pointer, the FIFO bookkeeping and the CPU handshake.
    always_comb begin
        scan_addr_d = frame_start ? '0 :
                      scan_gnt    ? ((scan_addr_q == LAST_ADDR) ? '0 : scan_addr_q + ADDR_W'(1)) :
                                    scan_addr_q;
        inflight_d  = scan_gnt;
        count_d     = frame_start ? '0 : count_q + (CW+1)'(push) - (CW+1)'(pop);
        wptr_d      = frame_start ? '0 : wptr_q + CW'(push);
        rptr_d      = frame_start ? '0 : rptr_q + CW'(pop);
        underflow_d = underflow_q || (pix_en && (count_q == '0) && !frame_start);
        state_d     = (state_q == S_BUSY) ? S_IDLE : (cpu_gnt ? S_BUSY : S_IDLE);
        we_d        = cpu_gnt ? cpu_we : we_q;
        rdata_d     = ((state_q == S_BUSY) && !we_q) ? ram_q : rdata_q;
        ram_addr_d  = cpu_gnt ? cpu_addr : (scan_gnt ? scan_addr_q : ram_addr_q);
        ram_wdata_d = cpu_gnt ? cpu_wdata : ram_wdata_q;
    end

    // Outputs are forced to their reset values while reset is high, so an aborted access never acks.
    always_comb begin
        ram_addr  = reset ? '0 : ram_addr_d;
        ram_wdata = reset ? '0 : ram_wdata_d;
        ram_wren  = cpu_gnt && cpu_we;
        cpu_ack   = !reset && (state_q == S_BUSY);
        cpu_rdata = reset ? '0 : rdata_d;
        pix_valid = !reset && (count_q != '0);
        pixel     = pix_valid ? mem_q[rptr_q] : '0;
        underflow = !reset && underflow_q;
    end

    // Control and handshake registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            scan_addr_q <= '0;
            inflight_q  <= 1'b0;
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            underflow_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            scan_addr_q <= scan_addr_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            underflow_q <= underflow_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // FIFO storage captures the registered RAM output one cycle after a scan grant.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem_q[wptr_q] <= ram_q;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of fill, CPU access, priority, pop bursts, wrap/restart and underflow/reset.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset, scan_en, frame_start, pix_en;
    logic [31:0] pixel;
    logic        pix_valid, underflow;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wren;
    logic [31:0] ram_q = '0;
    logic [31:0] ram [65536];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        found;

    vram_arbiter #(.ADDR_W(16), .DATA_W(32), .FIFO_DEPTH(4), .FRAME_WORDS(16)) dut (
        .clk(clk), .reset(reset), .scan_en(scan_en), .frame_start(frame_start), .pix_en(pix_en),
        .pixel(pixel), .pix_valid(pix_valid), .underflow(underflow),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with registered read data.
    always @(posedge clk) begin
        if (ram_wren) ram[ram_addr] <= ram_wdata;
        ram_q <= ram[ram_addr];
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 32'(i);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1; scan_en = 0; frame_start = 0; pix_en = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) cyc();
        #1;
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_pixel", pixel, 0);
        check("rst_underflow", 32'(underflow), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_ram_wren", 32'(ram_wren), 0);
        // fill: four consecutive scan grants from the first cycle out of reset
        cyc(); reset = 0; scan_en = 1; #1;
        check("fill_a0", 32'(ram_addr), 0);
        check("fill_v0", 32'(pix_valid), 0);
        cyc(); #1;
        check("fill_a1", 32'(ram_addr), 1);
        check("fill_v1", 32'(pix_valid), 0);
        cyc(); #1;
        check("fill_a2", 32'(ram_addr), 2);
        check("fill_v2", 32'(pix_valid), 1);
        check("fill_head", pixel, 0);
        cyc(); #1;
        check("fill_a3", 32'(ram_addr), 3);
        cyc(); #1;
        check("fill_stop", 32'(ram_addr), 3);
        cyc(); #1;
        check("fill_hold", 32'(ram_addr), 3);
        // CPU write while the FIFO is full, then read it back with req held through the ack
        cyc(); cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF; #1;
        check("wr_addr", 32'(ram_addr), 32'h10);
        check("wr_data", ram_wdata, 32'hDEADBEEF);
        check("wr_wren", 32'(ram_wren), 1);
        check("wr_ack_early", 32'(cpu_ack), 0);
        cyc(); #1;
        check("wr_ack", 32'(cpu_ack), 1);
        check("wr_wren_off", 32'(ram_wren), 0);
        cyc(); cpu_we = 0; #1;
        check("rd_addr", 32'(ram_addr), 32'h10);
        check("rd_wren", 32'(ram_wren), 0);
        check("rd_ack_early", 32'(cpu_ack), 0);
        cyc(); #1;
        check("rd_ack", 32'(cpu_ack), 1);
        check("rd_data", cpu_rdata, 32'hDEADBEEF);
        // drain to one entry with scanning off
        cyc(); cpu_req = 0; scan_en = 0; pix_en = 1; #1;
        check("rd_ack_off", 32'(cpu_ack), 0);
        check("rd_hold", cpu_rdata, 32'hDEADBEEF);
        check("pop0", pixel, 0);
        cyc(); #1;
        check("pop1", pixel, 1);
        cyc(); #1;
        check("pop2", pixel, 2);
        // urgent refill at occ=1 beats a pending CPU read
        cyc(); pix_en = 0; scan_en = 1; cpu_req = 1; #1;
        check("urg_scan", 32'(ram_addr), 4);
        check("urg_ack0", 32'(cpu_ack), 0);
        cyc(); #1;
        check("urg_cpu", 32'(ram_addr), 32'h10);
        check("urg_ack1", 32'(cpu_ack), 0);
        cyc(); #1;
        check("urg_ack", 32'(cpu_ack), 1);
        check("urg_data", cpu_rdata, 32'hDEADBEEF);
        check("urg_scan2", 32'(ram_addr), 5);
        // sustained pops with the CPU requesting continuously
        cyc(); pix_en = 1; #1;
        check("sus_cpu0", 32'(ram_addr), 32'h10);
        check("sus_px3", pixel, 3);
        cyc(); #1;
        check("sus_scan6", 32'(ram_addr), 6);
        check("sus_ack0", 32'(cpu_ack), 1);
        check("sus_px4", pixel, 4);
        cyc(); #1;
        check("sus_cpu1", 32'(ram_addr), 32'h10);
        check("sus_px5", pixel, 5);
        cyc(); #1;
        check("sus_scan7", 32'(ram_addr), 7);
        check("sus_ack1", 32'(cpu_ack), 1);
        check("sus_px6", pixel, 6);
        cyc(); pix_en = 0; #1;
        check("sus_stall_scan8", 32'(ram_addr), 8);
        check("sus_stall_noack", 32'(cpu_ack), 0);
        check("sus_empty", 32'(pix_valid), 0);
        cyc(); #1;
        check("sus_cpu2", 32'(ram_addr), 32'h10);
        check("sus_px7", pixel, 7);
        check("sus_no_uf", 32'(underflow), 0);
        cyc(); cpu_req = 0; #1;
        check("sus_ack2", 32'(cpu_ack), 1);
        check("sus_scan9", 32'(ram_addr), 9);
        // wrap: the grant after address 15 goes to 0
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc(); pix_en = 1; #1;
            found = (ram_addr == 16'd15);
        end
        check("wrap_reach", 32'(found), 1);
        for (int i = 0; i < 10 && ram_addr == 16'd15; i++) begin
            cyc(); #1;
        end
        check("wrap_zero", 32'(ram_addr), 0);
        check("wrap_no_uf", 32'(underflow), 0);
        cyc(); #1;
        check("wrap_a1", 32'(ram_addr), 1);
        cyc(); #1;
        check("wrap_a2", 32'(ram_addr), 2);
        cyc(); #1;
        check("wrap_a3", 32'(ram_addr), 3);
        // frame_start with the read of address 3 in flight, pop requested in the same cycle
        cyc(); frame_start = 1; #1;
        check("fs_noscan", 32'(ram_addr), 3);
        cyc(); frame_start = 0; pix_en = 0; #1;
        check("fs_flushed", 32'(pix_valid), 0);
        check("fs_no_uf", 32'(underflow), 0);
        check("fs_restart", 32'(ram_addr), 0);
        cyc(); #1;
        check("fs_a1", 32'(ram_addr), 1);
        check("fs_still_empty", 32'(pix_valid), 0);
        cyc(); #1;
        check("fs_valid", 32'(pix_valid), 1);
        check("fs_head", pixel, 0);
        // underflow on an empty FIFO is sticky
        cyc(); frame_start = 1; scan_en = 0; #1;
        cyc(); frame_start = 0; pix_en = 1; #1;
        check("uf_empty", 32'(pix_valid), 0);
        check("uf_pre", 32'(underflow), 0);
        cyc(); pix_en = 0; #1;
        check("uf_set", 32'(underflow), 1);
        // reset during a CPU read aborts it; arbitration restarts right after
        cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; #1;
        check("uf_stay", 32'(underflow), 1);
        check("rr_addr", 32'(ram_addr), 32'h10);
        cyc(); reset = 1; #1;
        check("rr_noack", 32'(cpu_ack), 0);
        check("rr_rdata", cpu_rdata, 0);
        check("rr_ram_addr", 32'(ram_addr), 0);
        cyc(); #1;
        check("rr_uf_clr", 32'(underflow), 0);
        check("rr_noack2", 32'(cpu_ack), 0);
        cyc(); reset = 0; #1;
        check("rr_noack3", 32'(cpu_ack), 0);
        check("rr_uf_low", 32'(underflow), 0);
        check("rr_regrant", 32'(ram_addr), 32'h10);
        cyc(); #1;
        check("rr_ack", 32'(cpu_ack), 1);
        check("rr_data", cpu_rdata, 32'hDEADBEEF);
        cyc(); cpu_req = 0; #1;
        check("rr_ack_off", 32'(cpu_ack), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have the following parameters.
- ADDR_W, default 16: frame-buffer word address width.
- DATA_W, default 32: pixel/word width.
- FIFO_DEPTH, default 4: scan-out prefetch FIFO entries (power of two, >=2).
- FRAME_WORDS, default 65536: words per frame; the scan address wraps here.

REQ-002 The block SHALL have the following ports, clock and reset first. There is one clock; reset is synchronous and active-high.
- clk, in, 1: single clock for all logic.
- reset, in, 1: synchronous, active-high reset.
- scan_en, in, 1: enables scan-out prefetch.
- frame_start, in, 1: one-cycle pulse that restarts scan-out at address 0.
- pix_en, in, 1: consumer pops one pixel this cycle.
- pixel, out, DATA_W: FIFO head word.
- pix_valid, out, 1: FIFO non-empty.
- underflow, out, 1: sticky flag, set by pix_en while the FIFO is empty.
- cpu_req, in, 1: CPU access request, held until cpu_ack.
- cpu_we, in, 1: 1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr, in, ADDR_W: CPU word address; stable while cpu_req is high.
- cpu_wdata, in, DATA_W: CPU write data; stable while cpu_req is high.
- cpu_ack, out, 1: one-cycle completion pulse.
- cpu_rdata, out, DATA_W: read data, valid while cpu_ack is high.
- ram_addr, out, ADDR_W: RAM address for this cycle.
- ram_wdata, out, DATA_W: RAM write data.
- ram_wren, out, 1: RAM write enable.
- ram_q, in, DATA_W: RAM read data, registered; valid one cycle after the address.

Function
REQ-003 The block SHALL grant the single RAM port to at most one of {SCAN, CPU} per cycle; with no grant, ram_wren=0 and ram_addr holds its last value.

REQ-004 The block SHALL compute occ = FIFO entries + scan reads in flight (0 or 1); SCAN is eligible when scan_en=1 and occ<FIFO_DEPTH.

REQ-005 The block SHALL define CPU eligibility as cpu_req=1, no CPU access in flight, and cpu_ack=0 this cycle.

REQ-006 The block SHALL use this priority order:
- occ<2 and SCAN eligible: SCAN wins (urgent refill).
- Otherwise, CPU eligible: CPU wins.
- Otherwise, SCAN eligible: SCAN wins.

REQ-007 On a SCAN grant, the block SHALL drive ram_addr=scan_addr and ram_wren=0, advance scan_addr by 1 (FRAME_WORDS-1 wraps to 0), and push ram_q into the FIFO on the next cycle.

REQ-008 On a CPU grant, the block SHALL drive ram_addr=cpu_addr, ram_wdata=cpu_wdata and ram_wren=cpu_we.

REQ-009 For every CPU grant in cycle N, cpu_ack SHALL be 1 in cycle N+1 only; for a read, cpu_rdata=ram_q in N+1 and otherwise holds its last value.

REQ-010 CPU throughput SHALL be at most one access per 2 cycles; a cpu_req still high in the ack cycle is a new request, eligible from ack+1.

REQ-011 The CPU-side state machine SHALL have two states.
- IDLE: on CPU grant, go to BUSY.
- BUSY: assert cpu_ack, then return to IDLE unconditionally.

REQ-012 pixel SHALL equal the FIFO head and pix_valid SHALL equal (FIFO count != 0).

REQ-013 A pix_en with pix_valid=1 SHALL pop the head; a simultaneous push and pop SHALL leave the count unchanged.

REQ-014 A pix_en with pix_valid=0 SHALL set underflow, pop nothing and leave the count at 0; underflow clears only on reset.

REQ-015 frame_start SHALL take effect in its own cycle:
- scan_addr=0 and the FIFO is flushed (count=0).
- Any scan read already in flight is discarded and not pushed.
- No SCAN grant is made that cycle.
- A CPU access in flight or being granted that cycle is unaffected.

REQ-016 frame_start together with pix_en SHALL flush the FIFO, and the pop SHALL neither pop nor set underflow.

REQ-017 scan_en=0 SHALL stop new SCAN grants only; a scan read already in flight still completes and is pushed, and popping continues.

REQ-018 The FIFO SHALL never exceed FIFO_DEPTH entries; this follows from REQ-004.

Reset
REQ-019 While reset=1 the block SHALL hold:
- scan_addr=0, FIFO empty, no reads in flight, state IDLE.
- pixel=0, pix_valid=0, underflow=0.
- cpu_ack=0, cpu_rdata=0.
- ram_addr=0, ram_wdata=0, ram_wren=0.

REQ-020 A reset asserted during a CPU access SHALL abort it; no cpu_ack is issued, and the requester re-issues.

REQ-021 Arbitration SHALL restart in the first cycle after reset is deasserted.

Verification
REQ-022 The bench SHALL cover these directed scenarios.
- Fill: reset, then scan_en=1, pix_en=0, RAM[i]=i -> grants at addresses 0,1,2,3 on consecutive cycles; pix_valid rises 2 cycles after reset release; FIFO holds 0..3; no further grants.
- CPU write during scan: FIFO full, cpu_req we=1, addr=0x0010, wdata=0xDEADBEEF -> ram_wren=1 with that address/data in the grant cycle; cpu_ack exactly 1 cycle later; a later CPU read of 0x0010 returns 0xDEADBEEF with its ack.
- Urgent priority: occ=1, CPU read pending -> SCAN is granted first, CPU in the next cycle; cpu_ack arrives 2 cycles after the request.
- Sustained pops: pix_en=1 every cycle with CPU requests continuous -> SCAN wins every slot once occ<2; the bench records that CPU stalls under occ<2 and that no underflow occurs.
- Wrap/restart: scan_addr=FRAME_WORDS-1, grant -> next scan address 0; frame_start mid-frame with a read in flight -> count=0, the discarded word is never seen on pixel, and the next grant is at address 0.
- Underflow/reset: pix_en on an empty FIFO -> underflow=1 and stays 1; reset during a CPU read -> no cpu_ack, and underflow=0.
